// File: rtl/lcd_write_sequencer_if.sv
// Handshake between the LCD control FSM (master) and the write-timing sequencer (slave).
interface lcd_write_sequencer_if;
    logic       write;
    logic       nibble_only;
    logic [7:0] data;
    logic       rs;
    logic       ready;
    logic       write_done;

    modport master (
        output write, nibble_only, data, rs,
        input  ready, write_done
    );

    modport slave (
        input  write, nibble_only, data, rs,
        output ready, write_done
    );
endinterface

// File: rtl/lcd_write_sequencer.sv
// Drives 4-bit character-LCD pins with setup, E-pulse, nibble-gap and execution-wait timing.
// Optional macro LCD_LONG_CMD_WAIT_EN: clear/return-home commands get the long execution wait.
module lcd_write_sequencer #(
    parameter int SETUP_CYCLES      = 2,
    parameter int PULSE_CYCLES      = 12,
    parameter int NIBBLE_GAP_CYCLES = 50,
    parameter int BYTE_WAIT_CYCLES  = 2000,
    parameter int CLEAR_WAIT_CYCLES = 82000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lcd_write_sequencer_if.slave  host,
    output logic                  lcd_e,
    output logic                  lcd_rs,
    output logic                  lcd_rw,
    output logic                  lcd_sf_ce,
    output logic [3:0]            lcd_data
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP_H, S_PULSE_H, S_GAP, S_SETUP_L, S_PULSE_L, S_WAIT, S_DONE
    } state_t;

    state_t      state, next_state;
    logic [19:0] count, next_count;
    logic [19:0] wait_load;
    logic [7:0]  cap_data, src_data;
    logic        cap_rs, src_rs;
    logic        cap_nib, src_nib;
    logic        long_wait;
    logic        bus_e, bus_rs;
    logic [3:0]  bus_data;

    assign lcd_rw    = 1'b0;
    assign lcd_sf_ce = 1'b1;

`ifdef LCD_LONG_CMD_WAIT_EN
    assign long_wait = !cap_rs && !cap_nib &&
                       (cap_data == 8'h01 || cap_data == 8'h02 || cap_data == 8'h03);
`else
    assign long_wait = 1'b0;
`endif

    assign wait_load = long_wait ? 20'(CLEAR_WAIT_CYCLES - 1) : 20'(BYTE_WAIT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    // Each state lasts (load + 1) cycles; the counter is reloaded only on a state change.
    always_comb begin
        next_state = state;
        next_count = (count != 20'd0) ? count - 20'd1 : 20'd0;
        src_data   = cap_data;
        src_rs     = cap_rs;
        src_nib    = cap_nib;
        bus_e      = 1'b0;
        bus_rs     = 1'b0;
        bus_data   = 4'h0;

        if (state == S_IDLE) begin
            src_data = host.data;
            src_rs   = host.rs;
            src_nib  = host.nibble_only;
        end

        case (state)
            S_IDLE: begin
                if (host.write) begin
                    next_state = S_SETUP_H;
                    next_count = 20'(SETUP_CYCLES - 1);
                end
            end
            S_SETUP_H: begin
                if (count == 20'd0) begin
                    next_state = S_PULSE_H;
                    next_count = 20'(PULSE_CYCLES - 1);
                end
            end
            S_PULSE_H: begin
                if (count == 20'd0) begin
                    if (cap_nib) begin
                        next_state = S_WAIT;
                        next_count = wait_load;
                    end else begin
                        next_state = S_GAP;
                        next_count = 20'(NIBBLE_GAP_CYCLES - 1);
                    end
                end
            end
            S_GAP: begin
                if (count == 20'd0) begin
                    next_state = S_SETUP_L;
                    next_count = 20'(SETUP_CYCLES - 1);
                end
            end
            S_SETUP_L: begin
                if (count == 20'd0) begin
                    next_state = S_PULSE_L;
                    next_count = 20'(PULSE_CYCLES - 1);
                end
            end
            S_PULSE_L: begin
                if (count == 20'd0) begin
                    next_state = S_WAIT;
                    next_count = wait_load;
                end
            end
            S_WAIT: begin
                if (count == 20'd0) begin
                    next_state = S_DONE;
                    next_count = 20'd0;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
                next_count = 20'd0;
            end
            default: begin
                next_state = S_IDLE;
                next_count = 20'd0;
            end
        endcase

        // Pins are decoded from the upcoming state so the registered outputs line up with it.
        case (next_state)
            S_SETUP_H, S_PULSE_H, S_GAP: begin
                bus_rs   = src_rs;
                bus_data = src_nib ? src_data[3:0] : src_data[7:4];
                bus_e    = (next_state == S_PULSE_H);
            end
            S_SETUP_L, S_PULSE_L, S_WAIT, S_DONE: begin
                bus_rs   = src_rs;
                bus_data = src_data[3:0];
                bus_e    = (next_state == S_PULSE_L);
            end
            default: begin
                bus_rs   = 1'b0;
                bus_data = 4'h0;
                bus_e    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cap_data        <= 8'h00;
            cap_rs          <= 1'b0;
            cap_nib         <= 1'b0;
            lcd_e           <= 1'b0;
            lcd_rs          <= 1'b0;
            lcd_data        <= 4'h0;
            host.ready      <= 1'b1;
            host.write_done <= 1'b0;
        end else begin
            if (state == S_IDLE && host.write) begin
                cap_data <= host.data;
                cap_rs   <= host.rs;
                cap_nib  <= host.nibble_only;
            end
            lcd_e           <= bus_e;
            lcd_rs          <= bus_rs;
            lcd_data        <= bus_data;
            host.ready      <= (next_state == S_IDLE);
            host.write_done <= (next_state == S_DONE);
        end
    end
endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Write-timing stage directly downstream of the LCD control/initialisation FSM on the 4-bit character-LCD path. It accepts one command/data byte, or a single init nibble, per handshake and drives the LCD bus pins with correct setup, enable-pulse, inter-nibble and execution-wait timing. It returns a one-cycle write-done pulse to the control FSM.

## Interface
- SETUP_CYCLES, 2 — cycles data/RS are stable before E rises (≥1)
- PULSE_CYCLES, 12 — E high width per nibble (≥1; 240 ns at 50 MHz)
- NIBBLE_GAP_CYCLES, 50 — E low between high and low nibble (≥1; 1 µs)
- BYTE_WAIT_CYCLES, 2000 — execution wait after last nibble (≥1; 40 µs)
- CLEAR_WAIT_CYCLES, 82000 — long wait for clear/home commands (≥1; 1.64 ms)
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-low reset
- iWrite  in  1  write request; level, held by upstream until oWriteDone
- iNibbleOnly  in  1  send only iData[3:0] as a single nibble (power-on init)
- iData  in  8  byte to send
- iRS  in  1  register select for this transfer (0 = command, 1 = data)
- oReady  out  1  high only in IDLE
- oWriteDone  out  1  one-cycle pulse when transfer, including wait, completes
- oLCD_Enabled  out  1  LCD E strobe
- oLCD_RegisterSelect  out  1  LCD RS
- oLCD_ReadWrite  out  1  constant 0
- oLCD_StrataFlashControl  out  1  constant 1
- oLCD_Data  out  4  LCD DB[7:4]

## Operation
- States: IDLE, SETUP_H, PULSE_H, GAP, SETUP_L, PULSE_L, WAIT, DONE. A single 20-bit down-counter is loaded on each state entry.
- IDLE: oReady=1, E=0, data=0, RS=0. On iWrite=1, capture iData, iRS and iNibbleOnly, then go to SETUP_H.
- SETUP_H: drive the first nibble and RS with E=0. The first nibble is iData[7:4], or iData[3:0] when iNibbleOnly. Lasts SETUP_CYCLES, then PULSE_H.
- PULSE_H: E=1 for PULSE_CYCLES. Next state is WAIT if nibble-only, else GAP.
- GAP: E=0 with the first nibble held, for NIBBLE_GAP_CYCLES, then SETUP_L.
- SETUP_L: drive iData[3:0] with E=0 for SETUP_CYCLES, then PULSE_L.
- PULSE_L: E=1 for PULSE_CYCLES, then WAIT.
- WAIT: E=0 with the last nibble and RS held. Lasts BYTE_WAIT_CYCLES, or CLEAR_WAIT_CYCLES when long-wait applies (see Configuration). Then DONE.
- DONE: oWriteDone=1 for exactly one cycle, oReady=0, then IDLE.
- Captured data is used for the whole transfer. Input changes after acceptance are ignored.
- iWrite still high in the cycle after DONE is treated as a new request. Upstream must drop iWrite on the edge where it samples oWriteDone.

## Timing
- Reset (Reset=0 at a rising edge) applies from any state, including mid-pulse or mid-wait:
  - state goes to IDLE, counter 0;
  - oLCD_Enabled=0, oLCD_Data=0, oLCD_RegisterSelect=0, oWriteDone=0, oReady=1 the cycle after Reset returns high;
  - the transfer is abandoned and no done pulse is issued.
- t0 is the accepting edge. E rises at t0+SETUP_CYCLES and stays high exactly PULSE_CYCLES cycles.
- Second E rise (byte mode) is at t0+2·S+P+G. Here S, P, G and W are the setup, pulse, gap and selected-wait parameters.
- oWriteDone is high in the cycle beginning at:
  - byte: t0+2S+2P+G+W, which is 2078 at defaults;
  - nibble-only: t0+S+P+W, which is 2014 at defaults.
- oReady is low from t0+1 through the DONE cycle. The earliest next acceptance is the edge ending the cycle after DONE.
- RS and data never change while E=1, or within the SETUP window before E rises.

## Configuration
- Macro: LCD_LONG_CMD_WAIT_EN.
- Defined: WAIT uses CLEAR_WAIT_CYCLES when all of these hold:
  - captured RS=0;
  - not nibble-only;
  - byte is 0x01, 0x02 or 0x03 (clear/return home).
- Undefined: WAIT always uses BYTE_WAIT_CYCLES, and CLEAR_WAIT_CYCLES is unused.

## Test plan
- Reset low 3 cycles, then high: all outputs at their reset values and oReady=1. With iWrite=0 for 100 cycles, no E activity.
- Byte 0x28, RS=0, defaults: nibble 0x2 then 0x8. E high 12 cycles twice, rises 64 cycles apart. oWriteDone at t0+2078.
- Nibble-only 0x3: single E pulse with data 0x3. oWriteDone at t0+2014. Upstream holds iWrite through done and drops it on that edge: exactly one transfer occurs.
- Byte 0x01, RS=0:
  - with LCD_LONG_CMD_WAIT_EN: oWriteDone at t0+82078;
  - without it: oWriteDone at t0+2078.
  - Byte 0x01 with RS=1: t0+2078 in both builds.
- Reset low during the second PULSE_L: E=0 next cycle, no oWriteDone, oReady=1 after release. A fresh 0x0C write then completes normally.
- Change iData/iRS every cycle after acceptance: the bus carries only the captured values, and RS/data are stable whenever E=1.
